// File: rtl/sad_search_engine.sv
// Full-search SAD motion estimation over a (2*SR)x(2*SR) candidate window.
// Consumes one 8-pixel reference row per cycle and reports the minimum-SAD motion vector.
module sad_search_engine #(
    parameter int SR    = 8,
    parameter int MV_W  = 5,
    parameter int SAD_W = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [511:0]           cur_in,
    input  logic                   ref_valid,
    input  logic [63:0]            ref_row,
    output logic                   ref_ready,
    output logic                   next_block,
    output logic                   busy,
    output logic                   done,
    output logic [SAD_W-1:0]       best_sad,
    output logic signed [MV_W-1:0] best_mvx,
    output logic signed [MV_W-1:0] best_mvy
);

    // state | meaning
    // IDLE  | waiting for start; best_* hold the last result
    // RUN   | accepting reference rows
    // DRAIN | last row accepted; pipeline finishing the final compare

    localparam int AXW      = $clog2(2 * SR);
    localparam int CW       = 2 * AXW;
    localparam int RW       = CW + 3;
    localparam int NUM_CAND = (2 * SR) * (2 * SR);
    localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_CAND * 8 - 1);
    localparam logic [CW-1:0] LAST_CAND = CW'(NUM_CAND - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nx;
    logic   next_block_nx, done_nx;

    logic [7:0][7:0][7:0] cur_blk;
    logic [RW-1:0]        row_cnt;
    logic                 accept, start_acc;

    logic                 s0_valid;
    logic [7:0][7:0]      s0_row;
    logic [RW-1:0]        s0_idx;

    logic                 s1_valid, s1_first, s1_last;
    logic [CW-1:0]        s1_cand;
    logic [7:0][7:0]      s1_diff, diff_nx;

    logic                 s2_valid;
    logic [CW-1:0]        s2_cand;
    logic [SAD_W-1:0]     acc;
    logic [10:0]          row_sum;

    assign ref_ready = (state == RUN);
    assign busy      = (state != IDLE);
    assign accept    = ref_valid && (state == RUN);
    assign start_acc = start && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            next_block <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            next_block <= next_block_nx;
            done       <= done_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        next_block_nx = 1'b0;
        done_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx      = RUN;
                    next_block_nx = 1'b1;
                end
            end
            RUN: begin
                if (accept && row_cnt == LAST_ROW)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                // final candidate's accumulator is ready; compare lands on this edge
                if (s2_valid && s2_cand == LAST_CAND) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        diff_nx = '0;
        for (int p = 0; p < 8; p++) begin
            if (cur_blk[s0_idx[2:0]][p] > s0_row[p])
                diff_nx[p] = cur_blk[s0_idx[2:0]][p] - s0_row[p];
            else
                diff_nx[p] = s0_row[p] - cur_blk[s0_idx[2:0]][p];
        end
    end

    always_comb begin
        row_sum = '0;
        for (int p = 0; p < 8; p++)
            row_sum = row_sum + 11'(s1_diff[p]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_row   <= '0;
            s0_idx   <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_cand  <= '0;
            s1_diff  <= '0;
            s2_valid <= 1'b0;
            s2_cand  <= '0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_row <= ref_row;
                s0_idx <= row_cnt;
            end
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_diff  <= diff_nx;
                s1_first <= (s0_idx[2:0] == 3'd0);
                s1_last  <= (s0_idx[2:0] == 3'd7);
                s1_cand  <= s0_idx[RW-1:3];
            end
            s2_valid <= s1_valid && s1_last;
            if (s1_valid)
                s2_cand <= s1_cand;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_blk  <= '0;
            row_cnt  <= '0;
            acc      <= '0;
            best_sad <= '0;
            best_mvx <= '0;
            best_mvy <= '0;
        end else if (start_acc) begin
            cur_blk  <= cur_in;
            row_cnt  <= '0;
            acc      <= '0;
            best_sad <= '1;
            best_mvx <= '0;
            best_mvy <= '0;
        end else begin
            if (accept)
                row_cnt <= row_cnt + RW'(1);
            if (s1_valid)
                acc <= s1_first ? SAD_W'(row_sum) : acc + SAD_W'(row_sum);
            // strict compare keeps the earliest candidate on ties
            if (s2_valid && acc < best_sad) begin
                best_sad <= acc;
                best_mvx <= MV_W'(s2_cand[AXW-1:0]) - MV_W'(SR);
                best_mvy <= MV_W'(s2_cand[CW-1:AXW]) - MV_W'(SR);
            end
        end
    end

endmodule

// File: tb/tb_sad_search_engine.sv
// Bench for sad_search_engine: directed and random searches checked against
// a brute-force SAD model over the whole candidate window.
module tb_sad_search_engine;

    logic               clk = 1'b0;
    logic               rst, start, ref_valid;
    logic [511:0]       cur_in;
    logic [63:0]        ref_row;
    logic               ref_ready, next_block, busy, done;
    logic [13:0]        best_sad;
    logic signed [4:0]  best_mvx, best_mvy;

    sad_search_engine #(.SR(8), .MV_W(5), .SAD_W(14)) dut (
        .clk(clk), .rst(rst), .start(start), .cur_in(cur_in),
        .ref_valid(ref_valid), .ref_row(ref_row), .ref_ready(ref_ready),
        .next_block(next_block), .busy(busy), .done(done),
        .best_sad(best_sad), .best_mvx(best_mvx), .best_mvy(best_mvy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int done_count = 0, done_cyc = 0, nb_count = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
        if (next_block === 1'b1) nb_count++;
    end

    int n_cmp = 0, n_bad = 0;
    logic [511:0] cur_blk_m;
    logic [63:0]  ref_mem [2048];

    logic nb1, rdy_drain, busy_drain;
    int   nb_total, last_edge, n_done, e_sad, e_c;
    bit   timeout;

    task automatic fill_uniform(input logic [7:0] cpx, input logic [7:0] rpx,
                                input int sc, input logic [7:0] spx);
        for (int i = 0; i < 64; i++) cur_blk_m[8*i +: 8] = cpx;
        for (int k = 0; k < 2048; k++) ref_mem[k] = ((k >> 3) == sc) ? {8{spx}} : {8{rpx}};
    endtask

    task automatic fill_random();
        int pick;
        for (int i = 0; i < 16; i++) cur_blk_m[32*i +: 32] = $urandom;
        for (int k = 0; k < 2048; k++) ref_mem[k] = {$urandom, $urandom};
        // plant a near match so the minimum is not just noise
        pick = $urandom_range(1, 255);
        for (int r = 0; r < 8; r++)
            ref_mem[pick*8 + r] = cur_blk_m[64*r +: 64] ^ {8{7'd0, 1'($urandom)}};
    endtask

    task automatic run_model(output int m_sad, output int m_c);
        int best, s, a, b;
        best = 1 << 30;
        m_c  = 0;
        for (int c = 0; c < 256; c++) begin
            s = 0;
            for (int r = 0; r < 8; r++)
                for (int p = 0; p < 8; p++) begin
                    a = int'(cur_blk_m[64*r + 8*p +: 8]);
                    b = int'(ref_mem[c*8 + r][8*p +: 8]);
                    s += (a > b) ? a - b : b - a;
                end
            if (s < best) begin
                best = s;
                m_c  = c;
            end
        end
        m_sad = best;
    endtask

    // gap_mode: 0 continuous, 1 alternating 1/0, 2 random gaps
    task automatic drive_search(input int gap_mode, input int inject_at, input int abort_at,
                                output logic o_nb1, output int o_nb_total, output int o_last_edge,
                                output int o_done, output logic o_rdy, output logic o_busy,
                                output bit o_timeout);
        int  rows = 0, guard = 0, d0, n0;
        bit  tog = 1'b1, injected = 1'b0;
        o_timeout = 1'b0; o_rdy = 1'b1; o_busy = 1'b0; o_last_edge = 0; o_done = 0;
        o_nb_total = 0;
        d0 = done_count;
        n0 = nb_count;
        @(negedge clk);
        start = 1'b1;
        cur_in = cur_blk_m;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) cur_in[32*i +: 32] = $urandom;
        o_nb1 = next_block;
        while (rows < 2048 && guard < 20000) begin
            guard++;
            case (gap_mode)
                0:       ref_valid = 1'b1;
                1:       begin ref_valid = tog; tog = !tog; end
                default: ref_valid = ($urandom_range(0, 3) != 0);
            endcase
            ref_row = ref_valid ? ref_mem[rows] : {$urandom, $urandom};
            start = 1'b0;
            if (inject_at >= 0 && rows == inject_at && !injected) begin
                start = 1'b1;
                injected = 1'b1;
            end
            if (abort_at >= 0 && rows == abort_at) begin
                rst = 1'b1;
                ref_valid = 1'b0;
                start = 1'b0;
                return;
            end
            if (ref_valid && ref_ready) begin
                rows++;
                o_last_edge = cyc + 1;
            end
            @(negedge clk);
        end
        ref_valid = 1'b0;
        start = 1'b0;
        if (rows < 2048) o_timeout = 1'b1;
        o_rdy  = ref_ready;
        o_busy = busy;
        guard = 0;
        while ((done_count - d0) == 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) @(negedge clk);
        if ((done_count - d0) == 0) o_timeout = 1'b1;
        o_done     = done_count - d0;
        o_nb_total = nb_count - n0;
    endtask

    task automatic test_reset();
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++;
        if (ref_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", ref_ready); end
        n_cmp++;
        if (done !== 1'b0 || next_block !== 1'b0) begin
            n_bad++; $display("FAIL reset_pulses: got done=%b next_block=%b expected 0/0", done, next_block);
        end
        n_cmp++;
        if (best_sad !== 14'd0 || best_mvx !== 5'sd0 || best_mvy !== 5'sd0) begin
            n_bad++; $display("FAIL reset_best: got %0d (%0d,%0d) expected 0 (0,0)", best_sad, best_mvx, best_mvy);
        end
        n_cmp++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_outlier_candidate();
        fill_uniform(8'h10, 8'h10, 37, 8'h20);
        run_model(e_sad, e_c);
        drive_search(0, -1, -1, nb1, nb_total, last_edge, n_done, rdy_drain, busy_drain, timeout);
        if (timeout) begin n_bad++; $display("FAIL outlier_timeout: got timeout expected done"); end
        n_cmp++;
        if (best_sad !== 14'(e_sad) || best_mvx !== 5'(e_c % 16 - 8) || best_mvy !== 5'(e_c / 16 - 8)) begin
            n_bad++; $display("FAIL outlier_best: got %0d (%0d,%0d) expected %0d (%0d,%0d)",
                              best_sad, best_mvx, best_mvy, e_sad, e_c % 16 - 8, e_c / 16 - 8);
        end
        n_cmp++;
        if (n_done != 1) begin n_bad++; $display("FAIL outlier_done_count: got %0d expected 1", n_done); end
        n_cmp++;
    endtask

    task automatic test_single_match(input int gap_mode);
        fill_uniform(8'h80, 8'h00, 100, 8'h7F);
        run_model(e_sad, e_c);
        drive_search(gap_mode, -1, -1, nb1, nb_total, last_edge, n_done, rdy_drain, busy_drain, timeout);
        if (best_sad !== 14'(e_sad) || best_mvx !== 5'(e_c % 16 - 8) || best_mvy !== 5'(e_c / 16 - 8)) begin
            n_bad++; $display("FAIL match%0d_best: got %0d (%0d,%0d) expected %0d (%0d,%0d)", gap_mode,
                              best_sad, best_mvx, best_mvy, e_sad, e_c % 16 - 8, e_c / 16 - 8);
        end
        n_cmp++;
        if (timeout || done_cyc != last_edge + 3) begin
            n_bad++; $display("FAIL match%0d_done_timing: got cycle %0d expected %0d", gap_mode, done_cyc, last_edge + 3);
        end
        n_cmp++;
        if (rdy_drain !== 1'b0 || busy_drain !== 1'b1) begin
            n_bad++; $display("FAIL match%0d_drain: got ready=%b busy=%b expected 0/1", gap_mode, rdy_drain, busy_drain);
        end
        n_cmp++;
        if (busy !== 1'b0 || n_done != 1) begin
            n_bad++; $display("FAIL match%0d_idle: got busy=%b dones=%0d expected 0/1", gap_mode, busy, n_done);
        end
        n_cmp++;
    endtask

    task automatic test_saturated_tie();
        fill_uniform(8'hFF, 8'h00, -1, 8'h00);
        run_model(e_sad, e_c);
        drive_search(0, -1, -1, nb1, nb_total, last_edge, n_done, rdy_drain, busy_drain, timeout);
        if (best_sad !== 14'(e_sad)) begin n_bad++; $display("FAIL sat_sad: got %0d expected %0d", best_sad, e_sad); end
        n_cmp++;
        if (best_mvx !== 5'(e_c % 16 - 8) || best_mvy !== 5'(e_c / 16 - 8)) begin
            n_bad++; $display("FAIL sat_tie_mv: got (%0d,%0d) expected (%0d,%0d)", best_mvx, best_mvy, e_c % 16 - 8, e_c / 16 - 8);
        end
        n_cmp++;
    endtask

    task automatic test_restart_ignored();
        fill_random();
        run_model(e_sad, e_c);
        drive_search(2, 300, -1, nb1, nb_total, last_edge, n_done, rdy_drain, busy_drain, timeout);
        if (nb1 !== 1'b1) begin n_bad++; $display("FAIL restart_nb_after_start: got %b expected 1", nb1); end
        n_cmp++;
        if (nb_total != 1) begin n_bad++; $display("FAIL restart_nb_pulses: got %0d expected 1", nb_total); end
        n_cmp++;
        if (best_sad !== 14'(e_sad) || best_mvx !== 5'(e_c % 16 - 8) || best_mvy !== 5'(e_c / 16 - 8)) begin
            n_bad++; $display("FAIL restart_best: got %0d (%0d,%0d) expected %0d (%0d,%0d)",
                              best_sad, best_mvx, best_mvy, e_sad, e_c % 16 - 8, e_c / 16 - 8);
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_search();
        int dc;
        fill_random();
        dc = done_count;
        drive_search(0, -1, 500, nb1, nb_total, last_edge, n_done, rdy_drain, busy_drain, timeout);
        #1;
        if (busy !== 1'b0 || ref_ready !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL abort_ctrl: got busy=%b ready=%b done=%b expected 0/0/0", busy, ref_ready, done);
        end
        n_cmp++;
        if (best_sad !== 14'd0 || best_mvx !== 5'sd0 || best_mvy !== 5'sd0) begin
            n_bad++; $display("FAIL abort_best: got %0d (%0d,%0d) expected 0 (0,0)", best_sad, best_mvx, best_mvy);
        end
        n_cmp++;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        if (done_count != dc) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_count - dc); end
        n_cmp++;
        fill_random();
        run_model(e_sad, e_c);
        drive_search(2, -1, -1, nb1, nb_total, last_edge, n_done, rdy_drain, busy_drain, timeout);
        if (best_sad !== 14'(e_sad) || best_mvx !== 5'(e_c % 16 - 8) || best_mvy !== 5'(e_c / 16 - 8)) begin
            n_bad++; $display("FAIL after_abort_best: got %0d (%0d,%0d) expected %0d (%0d,%0d)",
                              best_sad, best_mvx, best_mvy, e_sad, e_c % 16 - 8, e_c / 16 - 8);
        end
        n_cmp++;
        if (timeout || n_done != 1) begin n_bad++; $display("FAIL after_abort_done: got %0d pulses expected 1", n_done); end
        n_cmp++;
    endtask

    task automatic test_random_back_to_back();
        for (int run = 0; run < 2; run++) begin
            fill_random();
            run_model(e_sad, e_c);
            drive_search(2, -1, -1, nb1, nb_total, last_edge, n_done, rdy_drain, busy_drain, timeout);
            if (best_sad !== 14'(e_sad) || best_mvx !== 5'(e_c % 16 - 8) || best_mvy !== 5'(e_c / 16 - 8)) begin
                n_bad++; $display("FAIL random%0d_best: got %0d (%0d,%0d) expected %0d (%0d,%0d)", run,
                                  best_sad, best_mvx, best_mvy, e_sad, e_c % 16 - 8, e_c / 16 - 8);
            end
            n_cmp++;
            if (timeout || done_cyc != last_edge + 3) begin
                n_bad++; $display("FAIL random%0d_done_timing: got cycle %0d expected %0d", run, done_cyc, last_edge + 3);
            end
            n_cmp++;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ref_valid = 1'b0;
        cur_in = '0;
        ref_row = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_outlier_candidate();
        test_single_match(0);
        test_single_match(1);
        test_saturated_tie();
        test_restart_ignored();
        test_reset_mid_search();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
